// File: rtl/univ_shift_reg.sv
// Universal shift register: parallel load plus counted rotate/logical shift runs.
// Shift direction and type are latched at start; ser_in is sampled on every shift edge.
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic [1:0]       mode,
    input  logic             ser_in,
    output logic [WIDTH-1:0] op,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [1:0] M_ROL = 2'b00;
    localparam logic [1:0] M_ROR = 2'b01;
    localparam logic [1:0] M_SHL = 2'b10;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] op_q, op_n;
    logic             so_q, so_n;
    logic             done_q, done_n;
    logic [CNT_W-1:0] rem_q, rem_n;
    logic [1:0]       mode_q, mode_n;

    logic [WIDTH-1:0] shifted;
    logic             shout;

    // One shift step per the latched mode; shout is the bit leaving the register.
    always_comb begin
        shifted = op_q;
        shout   = so_q;
        case (mode_q)
            M_ROL: begin
                shifted = {op_q[WIDTH-2:0], op_q[WIDTH-1]};
                shout   = op_q[WIDTH-1];
            end
            M_ROR: begin
                shifted = {op_q[0], op_q[WIDTH-1:1]};
                shout   = op_q[0];
            end
            M_SHL: begin
                shifted = {op_q[WIDTH-2:0], ser_in};
                shout   = op_q[WIDTH-1];
            end
            default: begin
                shifted = {ser_in, op_q[WIDTH-1:1]};
                shout   = op_q[0];
            end
        endcase
    end

    always_comb begin
        state_n = state_q;
        op_n    = op_q;
        so_n    = so_q;
        done_n  = 1'b0;
        rem_n   = rem_q;
        mode_n  = mode_q;
        if (load_en) begin
            // Load wins over everything, including an in-flight run and start.
            op_n    = load_val;
            state_n = IDLE;
            rem_n   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (count == '0) begin
                            done_n = 1'b1;
                        end else begin
                            mode_n  = mode;
                            rem_n   = count;
                            state_n = RUN;
                        end
                    end
                end
                RUN: begin
                    op_n  = shifted;
                    so_n  = shout;
                    rem_n = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q    <= '0;
            so_q    <= 1'b0;
            done_q  <= 1'b0;
            rem_q   <= '0;
            mode_q  <= 2'b00;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            so_q    <= so_n;
            done_q  <= done_n;
            rem_q   <= rem_n;
            mode_q  <= mode_n;
        end
    end

    assign op      = op_q;
    assign ser_out = so_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg; outputs sampled 1ns after each rising edge.
module tb_univ_shift_reg;

    logic       clk = 1'b0;
    logic       rstn;
    logic       load_en;
    logic [7:0] load_val;
    logic       start;
    logic [4:0] count;
    logic [1:0] mode;
    logic       ser_in;
    logic [7:0] op;
    logic       ser_out;
    logic       busy;
    logic       done;

    int errors = 0;
    int checks = 0;

    univ_shift_reg #(.WIDTH(8), .CNT_W(5)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .load_en  (load_en),
        .load_val (load_val),
        .start    (start),
        .count    (count),
        .mode     (mode),
        .ser_in   (ser_in),
        .op       (op),
        .ser_out  (ser_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] v);
        load_en  = 1'b1;
        load_val = v;
        tick();
        load_en  = 1'b0;
    endtask

    task automatic kick(input logic [1:0] m, input logic [4:0] n);
        mode  = m;
        count = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; load_en = 1'b0; load_val = '0; start = 1'b0;
        count = '0; mode = 2'b00; ser_in = 1'b0;

        // Reset and idle
        repeat (2) tick();
        rstn = 1'b1;
        check("rst_op", op, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_so", ser_out, 0);
        repeat (5) tick();
        check("idle_op", op, 8'h00);

        // Rotate left x3; start/mode/count toggled mid-run must be ignored
        load(8'h01);
        check("ld01", op, 8'h01);
        mode = 2'b00; count = 5'd3; start = 1'b1;
        tick();
        mode = 2'b11; count = 5'd1;
        check("rol_busy0", busy, 1);
        check("rol_hold", op, 8'h01);
        tick();
        start = 1'b0;
        check("rol_1", op, 8'h02);
        check("rol_busy1", busy, 1);
        tick();
        check("rol_2", op, 8'h04);
        tick();
        check("rol_3", op, 8'h08);
        check("rol_busy_end", busy, 0);
        check("rol_done", done, 1);
        tick();
        check("rol_done_w", done, 0);
        check("rol_keep", op, 8'h08);

        // Rotate right x9 wraps past WIDTH
        load(8'h01);
        kick(2'b01, 5'd9);
        tick();
        check("ror_1", op, 8'h80);
        check("ror_so", ser_out, 1);
        repeat (7) tick();
        check("ror_8", op, 8'h01);
        check("ror_busy8", busy, 1);
        tick();
        check("ror_9", op, 8'h80);
        check("ror_done", done, 1);

        // Logical right filling ones, then logical left filling zeros
        load(8'h00);
        ser_in = 1'b1;
        kick(2'b11, 5'd4);
        repeat (4) tick();
        check("lsr_4", op, 8'hF0);
        check("lsr_so", ser_out, 0);
        check("lsr_done", done, 1);
        ser_in = 1'b0;
        kick(2'b10, 5'd2);
        tick();
        check("lsl_1", op, 8'hE0);
        tick();
        check("lsl_2", op, 8'hC0);
        check("lsl_so", ser_out, 1);
        check("lsl_done", done, 1);

        // Load aborts a run; zero-count start only pulses done
        load(8'h81);
        kick(2'b00, 5'd10);
        tick();
        check("ab_1", op, 8'h03);
        tick();
        check("ab_2", op, 8'h06);
        load_en = 1'b1; load_val = 8'h55; start = 1'b1; count = 5'd2;
        tick();
        load_en = 1'b0; start = 1'b0;
        check("ab_op", op, 8'h55);
        check("ab_busy", busy, 0);
        check("ab_done", done, 0);
        tick();
        check("ab_done2", done, 0);
        check("ab_busy2", busy, 0);
        kick(2'b00, 5'd0);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_op", op, 8'h55);
        tick();
        check("z_done_w", done, 0);
        check("z_op2", op, 8'h55);

        // Asynchronous reset mid-run
        kick(2'b00, 5'd6);
        tick();
        check("rr_1", op, 8'hAA);
        #2 rstn = 1'b0;
        #1;
        check("ar_op", op, 8'h00);
        check("ar_busy", busy, 0);
        check("ar_done", done, 0);
        check("ar_so", ser_out, 0);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        check("ar_done_post", done, 0);
        check("ar_busy_post", busy, 0);
        ser_in = 1'b1;
        kick(2'b10, 5'd1);
        check("pr_busy", busy, 1);
        tick();
        check("pr_op", op, 8'h01);
        check("pr_done", done, 1);
        check("pr_busy_end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
